// File: rtl/imm_encoder_pkg.sv
// ============================================================================
// Module  : imm_encoder_pkg
// Brief   : Shared format codes, FSM encodings and field offsets for imm_encoder.
// Revision: 1.0
// ============================================================================
`default_nettype none

package imm_encoder_pkg;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_FULL  = 2'd1;
    localparam logic [1:0] S_HI    = 2'd2;

    localparam int RD_LSB  = 0;
    localparam int RS1_LSB = 8;

    // True when v is a sign-extended w-bit quantity.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned w);
        logic [31:0] mask;
        mask = 32'hFFFF_FFFF << (w - 32'd1);
        return ((v & mask) == mask) || ((v & mask) == 32'h0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/imm_pack.sv
// ============================================================================
// Module  : imm_pack
// Brief   : Combinational scatter of a signed immediate into instr[31:7].
// Revision: 1.0
// ============================================================================
`default_nettype none

module imm_pack
    import imm_encoder_pkg::*;
(
    input  logic [1:0]  fmt_i,
    input  logic [31:0] imm_i,
    input  logic [24:0] base_i,
    output logic [24:0] field_o,
    output logic        err_o
);

    always_comb begin
        field_o = base_i;
        err_o   = 1'b0;
        case (fmt_i)
            IMM_I: begin
                field_o[24:13] = imm_i[11:0];
                err_o          = !fits_signed(imm_i, 12);
            end
            IMM_S: begin
                field_o[24:18] = imm_i[11:5];
                field_o[4:0]   = imm_i[4:0];
                err_o          = !fits_signed(imm_i, 12);
            end
            IMM_B: begin
                field_o[24]    = imm_i[12];
                field_o[23:18] = imm_i[10:5];
                field_o[4:1]   = imm_i[4:1];
                field_o[0]     = imm_i[11];
                err_o          = !fits_signed(imm_i, 13) || imm_i[0];
            end
            default: begin
                field_o[24]    = imm_i[20];
                field_o[23:14] = imm_i[10:1];
                field_o[13]    = imm_i[11];
                field_o[12:5]  = imm_i[19:12];
                err_o          = !fits_signed(imm_i, 21) || imm_i[0];
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/imm_encoder.sv
// ============================================================================
// Module  : imm_encoder
// Brief   : Valid/ready immediate packer with optional LUI+ADDI expansion.
// Revision: 1.0
// ============================================================================
`default_nettype none

module imm_encoder
    import imm_encoder_pkg::*;
#(
    parameter logic EXPAND_LI = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_immcntrl,
    input  logic [31:0] in_imm,
    input  logic [24:0] in_base,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [24:0] out_field,
    output logic        out_upper,
    output logic        out_last,
    output logic        out_err
);

    logic [1:0]  state_q, state_d;
    logic [24:0] field_q;
    logic        upper_q, last_q, err_q;
    logic [11:0] lo_imm_q;
    logic [24:0] lo_base_q;

    logic [1:0]  w_pack_fmt;
    logic [31:0] w_pack_imm;
    logic [24:0] w_pack_base;
    logic [24:0] w_pack_field;
    logic        w_pack_err;
    logic [24:0] w_lo_base;
    logic [19:0] w_hi;
    logic        w_accept, w_expand, w_load_lo;

    // The packer is shared: the pending low beat borrows it while in S_HI.
    assign w_pack_fmt  = (state_q == S_HI) ? IMM_I : in_immcntrl;
    assign w_pack_imm  = (state_q == S_HI) ? {{20{lo_imm_q[11]}}, lo_imm_q} : in_imm;
    assign w_pack_base = (state_q == S_HI) ? lo_base_q : in_base;

    imm_pack u_pack (
        .fmt_i   (w_pack_fmt),
        .imm_i   (w_pack_imm),
        .base_i  (w_pack_base),
        .field_o (w_pack_field),
        .err_o   (w_pack_err)
    );

    // (imm + 0x800) >> 12 equals imm[31:12] plus the carry out of the low half.
    assign w_hi      = in_imm[31:12] + {19'd0, in_imm[11]};
    assign w_accept  = in_valid && in_ready;
    assign w_expand  = EXPAND_LI && (state_q != S_HI) && (in_immcntrl == IMM_I) && w_pack_err;
    assign w_load_lo = (state_q == S_HI) && out_ready;

    always_comb begin
        w_lo_base                 = in_base;
        w_lo_base[RS1_LSB +: 5]   = in_base[RD_LSB +: 5];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_EMPTY;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: if (w_accept) state_d = w_expand ? S_HI : S_FULL;
            S_FULL: begin
                if (out_ready) begin
                    if (w_accept) state_d = w_expand ? S_HI : S_FULL;
                    else          state_d = S_EMPTY;
                end
            end
            S_HI:    if (out_ready) state_d = S_FULL;
            default: state_d = S_EMPTY;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_EMPTY) || ((state_q == S_FULL) && out_ready);
        out_valid = (state_q != S_EMPTY);
        out_field = field_q;
        out_upper = upper_q;
        out_last  = last_q;
        out_err   = err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            field_q   <= 25'd0;
            upper_q   <= 1'b0;
            last_q    <= 1'b0;
            err_q     <= 1'b0;
            lo_imm_q  <= 12'd0;
            lo_base_q <= 25'd0;
        end else if (w_accept) begin
            if (w_expand) begin
                field_q   <= {w_hi, in_base[RD_LSB +: 5]};
                upper_q   <= 1'b1;
                last_q    <= 1'b0;
                err_q     <= 1'b0;
                lo_imm_q  <= in_imm[11:0];
                lo_base_q <= w_lo_base;
            end else begin
                field_q <= w_pack_field;
                upper_q <= 1'b0;
                last_q  <= 1'b1;
                err_q   <= w_pack_err;
            end
        end else if (w_load_lo) begin
            field_q <= w_pack_field;
            upper_q <= 1'b0;
            last_q  <= 1'b1;
            err_q   <= w_pack_err;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_imm_encoder.sv
// ============================================================================
// Module  : tb_imm_encoder
// Brief   : Self-checking bench for imm_encoder against an instruction-level model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_immcntrl = 2'b00;
    logic [31:0] in_imm = 32'd0;
    logic [24:0] in_base = 25'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [24:0] out_field;
    logic        out_upper, out_last, out_err;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [24:0] f;
        logic        u;
        logic        l;
        logic        e;
    } beat_t;

    beat_t q[$];

    imm_encoder #(.EXPAND_LI(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_immcntrl (in_immcntrl),
        .in_imm      (in_imm),
        .in_base     (in_base),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_field   (out_field),
        .out_upper   (out_upper),
        .out_last    (out_last),
        .out_err     (out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model: build the whole 32-bit instruction in standard RISC-V layout, keep [31:7].
    function automatic logic [24:0] m_pack(input logic [1:0] f, input logic [31:0] imm,
                                           input logic [24:0] base);
        logic [31:0] ins;
        ins = {base, 7'b0};
        case (f)
            2'b00: ins[31:20] = imm[11:0];
            2'b01: begin ins[31:25] = imm[11:5]; ins[11:7] = imm[4:0]; end
            2'b10: begin
                ins[31] = imm[12]; ins[30:25] = imm[10:5];
                ins[11:8] = imm[4:1]; ins[7] = imm[11];
            end
            default: begin
                ins[31] = imm[20]; ins[30:21] = imm[10:1];
                ins[20] = imm[11]; ins[19:12] = imm[19:12];
            end
        endcase
        return ins[31:7];
    endfunction

    function automatic logic m_legal(input logic [1:0] f, input logic [31:0] imm);
        longint s;
        s = longint'($signed(imm));
        case (f)
            2'b00, 2'b01: return (s >= -2048) && (s <= 2047);
            2'b10:        return (s >= -4096) && (s <= 4095) && (imm[0] == 1'b0);
            default:      return (s >= -1048576) && (s <= 1048575) && (imm[0] == 1'b0);
        endcase
    endfunction

    function automatic logic [19:0] m_hi(input logic [31:0] imm);
        logic [31:0] t;
        t = (imm + 32'h800) >> 12;
        return t[19:0];
    endfunction

    task automatic push_req(input logic [1:0] f, input logic [31:0] imm, input logic [24:0] base);
        beat_t b;
        logic [24:0] b2;
        if (f == 2'b00 && !m_legal(f, imm)) begin
            b.f = {m_hi(imm), base[4:0]}; b.u = 1'b1; b.l = 1'b0; b.e = 1'b0;
            q.push_back(b);
            b2 = base;
            b2[12:8] = base[4:0];
            b.f = m_pack(2'b00, imm, b2); b.u = 1'b0; b.l = 1'b1; b.e = 1'b0;
            q.push_back(b);
        end else begin
            b.f = m_pack(f, imm, base); b.u = 1'b0; b.l = 1'b1; b.e = !m_legal(f, imm);
            q.push_back(b);
        end
    endtask

    // Single compare process: handshakes, occupancy and the head beat every cycle.
    always @(negedge clk) begin
        logic exp_ov, exp_ir;
        #2;
        if (!rst_n) begin
            q.delete();
        end else begin
            exp_ov = (q.size() != 0);
            exp_ir = (q.size() == 0) || ((q.size() == 1) && out_ready);
            chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
            chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
            if (exp_ov && out_valid) begin
                chk("out_field", {7'd0, out_field}, {7'd0, q[0].f});
                chk("out_upper", {31'd0, out_upper}, {31'd0, q[0].u});
                chk("out_last", {31'd0, out_last}, {31'd0, q[0].l});
                chk("out_err", {31'd0, out_err}, {31'd0, q[0].e});
            end
            if (exp_ov && out_ready) void'(q.pop_front());
            if (in_valid && exp_ir) push_req(in_immcntrl, in_imm, in_base);
        end
    end

    task automatic drive(input logic v, input logic [1:0] f, input logic [31:0] imm,
                         input logic [24:0] b, input logic r);
        @(negedge clk);
        in_valid = v; in_immcntrl = f; in_imm = imm; in_base = b; out_ready = r;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_field"}, {7'd0, out_field}, 32'd0);
        chk({tag, "_upper"}, {31'd0, out_upper}, 32'd0);
        chk({tag, "_last"}, {31'd0, out_last}, 32'd0);
        chk({tag, "_err"}, {31'd0, out_err}, 32'd0);
    endtask

    logic [31:0] edges [16] = '{32'h7FF, 32'h800, 32'hFFFFF800, 32'hFFFFF7FF,
                                32'hFFF, 32'h1000, 32'hFFFFF000, 32'hFFFFEFFF,
                                32'h000FFFFE, 32'h00100000, 32'hFFF00000, 32'hFFEFFFFE,
                                32'h7FFFF800, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};

    function automatic logic [31:0] rnd_imm();
        case ($urandom_range(0, 3))
            0:       return $urandom_range(0, 4095) - 32'd2048;
            1:       return edges[$urandom_range(0, 15)];
            2:       return $urandom_range(0, 32'h3FFFFF) - 32'h200000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        // Model pins against hand-computed values.
        chk("pin_I_7FF", {7'd0, m_pack(2'b00, 32'h7FF, 25'd0)}, 32'h0FFE000);
        chk("pin_S_m4", {7'd0, m_pack(2'b01, 32'hFFFFFFFC, 25'd0)}, 32'h1FC001C);
        chk("pin_B_odd", {31'd0, m_legal(2'b10, 32'h5)}, 32'd0);
        chk("pin_J_range", {31'd0, m_legal(2'b11, 32'h00100000)}, 32'd0);
        chk("pin_I_legal", {31'd0, m_legal(2'b00, 32'h7FF)}, 32'd1);
        chk("pin_hi", {12'd0, m_hi(32'h12345FFF)}, 32'h12346);
        chk("pin_lo_pack", {7'd0, m_pack(2'b00, 32'h12345FFF, 25'h00303)}, 32'h1FFE303);

        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        rst_n = 1'b1;

        // Directed vectors.
        drive(1'b1, 2'b00, 32'h7FF, 25'd0, 1'b1);
        drive(1'b1, 2'b01, 32'hFFFFFFFC, 25'd0, 1'b1);
        drive(1'b1, 2'b10, 32'h5, 25'd0, 1'b1);
        drive(1'b1, 2'b11, 32'h00100000, 25'd0, 1'b1);
        drive(1'b1, 2'b00, 32'h12345FFF, 25'd3, 1'b1);
        repeat (3) drive(1'b1, 2'b00, 32'h100, 25'h1ABCDE, 1'b1);

        // Stall with a held beat, then release into back-to-back traffic.
        drive(1'b1, 2'b01, 32'h123, 25'h155555, 1'b0);
        repeat (5) drive(1'b1, 2'b11, 32'h2468, 25'h0AAAAA, 1'b0);
        repeat (4) drive(1'b1, 2'b10, rnd_imm() & 32'hFFFFFFFE, $urandom, 1'b1);

        // Reset while the low beat of an expansion is pending.
        repeat (3) drive(1'b0, 2'b00, 32'd0, 25'd0, 1'b1);
        drive(1'b1, 2'b00, 32'h12345FFF, 25'd3, 1'b0);
        drive(1'b0, 2'b00, 32'd0, 25'd0, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk("async_drop", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) drive(1'b0, 2'b00, 32'd0, 25'd0, 1'b1);

        // Randomised traffic.
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)), rnd_imm(),
                  25'($urandom), ($urandom_range(0, 9) < 7));
        end

        repeat (6) drive(1'b0, 2'b00, 32'd0, 25'd0, 1'b1);
        @(negedge clk);
        #3 chk("drained", q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
